// File: rtl/vocab_scan_matcher.sv
// Vocabulary scanner: compares a latched query word against a register-array
// vocabulary, LANES entries per cycle, in exact or longest-prefix mode.
module vocab_scan_matcher #(
    parameter int ADDR_WIDTH  = 4,
    parameter int WORD_LENGTH = 3,
    parameter int DATA_WIDTH  = 8,
    parameter int LANES       = 2
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              cs,
    input  logic                              mode,
    input  logic [WORD_LENGTH*DATA_WIDTH-1:0] word,
    input  logic                              wr_en,
    input  logic [ADDR_WIDTH-1:0]             wr_addr,
    input  logic [WORD_LENGTH*DATA_WIDTH-1:0] wr_data,
    output logic                              busy,
    output logic                              done,
    output logic                              found,
    output logic [ADDR_WIDTH-1:0]             match_addr,
    output logic [$clog2(WORD_LENGTH+1)-1:0]  match_len,
    output logic [1:0]                        state_dbg
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int WW    = WORD_LENGTH * DATA_WIDTH;
    localparam int LW    = $clog2(WORD_LENGTH + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SCAN = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Handshake: cs is a request sampled only in IDLE (mode/word latched with it);
    // done is a one-cycle pulse after which found/match_addr/match_len stay valid
    // until the next accepted cs. No back-pressure: the requester simply waits.

    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] base;
    logic [WW-1:0]         word_q;
    logic                  mode_q;
    logic [LW-1:0]         best_len;
    logic [ADDR_WIDTH-1:0] best_addr;
    logic [WW-1:0]         vocab [DEPTH];

    logic                  grp_null;
    logic                  hit;
    logic [ADDR_WIDTH-1:0] hit_addr;
    logic [LW-1:0]         nb_len;
    logic [ADDR_WIDTH-1:0] nb_addr;
    logic                  last_grp;
    logic                  query_zero;
    logic                  term;
    logic                  res_found;
    logic [ADDR_WIDTH-1:0] res_addr;
    logic [LW-1:0]         res_len;

    function automatic logic [LW-1:0] prefix_len(input logic [WW-1:0] a,
                                                 input logic [WW-1:0] b);
        logic [LW-1:0] n;
        logic          run;
        n   = '0;
        run = 1'b1;
        for (int c = WORD_LENGTH - 1; c >= 0; c--) begin
            if (run && a[c*DATA_WIDTH +: DATA_WIDTH] == b[c*DATA_WIDTH +: DATA_WIDTH])
                n = n + LW'(1);
            else
                run = 1'b0;
        end
        return n;
    endfunction

    // A null entry invalidates itself and every higher lane of the group.
    always_comb begin
        grp_null = 1'b0;
        hit      = 1'b0;
        hit_addr = '0;
        nb_len   = best_len;
        nb_addr  = best_addr;
        for (int i = 0; i < LANES; i++) begin
            if (vocab[base + ADDR_WIDTH'(i)] == '0) begin
                grp_null = 1'b1;
            end else if (!grp_null) begin
                if (!hit && vocab[base + ADDR_WIDTH'(i)] == word_q) begin
                    hit      = 1'b1;
                    hit_addr = base + ADDR_WIDTH'(i);
                end
                if (prefix_len(vocab[base + ADDR_WIDTH'(i)], word_q) > nb_len) begin
                    nb_len  = prefix_len(vocab[base + ADDR_WIDTH'(i)], word_q);
                    nb_addr = base + ADDR_WIDTH'(i);
                end
            end
        end
    end

    always_comb begin
        last_grp   = (base == ADDR_WIDTH'(DEPTH - LANES));
        query_zero = (word_q == '0);
        term       = (!mode_q && hit) || grp_null || last_grp || query_zero;
        res_found  = 1'b0;
        res_addr   = '0;
        res_len    = '0;
        if (!query_zero) begin
            if (!mode_q) begin
                if (hit) begin
                    res_found = 1'b1;
                    res_addr  = hit_addr;
                    res_len   = LW'(WORD_LENGTH);
                end
            end else if (nb_len != '0) begin
                res_found = 1'b1;
                res_addr  = nb_addr;
                res_len   = nb_len;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            base       <= '0;
            word_q     <= '0;
            mode_q     <= 1'b0;
            best_len   <= '0;
            best_addr  <= '0;
            found      <= 1'b0;
            match_addr <= '0;
            match_len  <= '0;
            for (int i = 0; i < DEPTH; i++) vocab[i] <= '0;
        end else begin
            if (wr_en && state != SCAN) vocab[wr_addr] <= wr_data;
            case (state)
                IDLE: begin
                    if (cs) begin
                        state      <= SCAN;
                        word_q     <= word;
                        mode_q     <= mode;
                        base       <= '0;
                        best_len   <= '0;
                        best_addr  <= '0;
                        found      <= 1'b0;
                        match_addr <= '0;
                        match_len  <= '0;
                    end
                end
                SCAN: begin
                    if (term) begin
                        state      <= DONE;
                        found      <= res_found;
                        match_addr <= res_addr;
                        match_len  <= res_len;
                    end else begin
                        base      <= base + ADDR_WIDTH'(LANES);
                        best_len  <= nb_len;
                        best_addr <= nb_addr;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy      = (state == SCAN);
    assign done      = (state == DONE);
    assign state_dbg = state;

endmodule
